// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned UartByteW = 8;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Index width for a requester vector; at least one bit.
  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stall counter width; a disabled timeout (0) still gets a 1-bit counter.
  function automatic int unsigned arb_cnt_w(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first requester at or above prio_i,
// wrapping to the lowest index when nothing at or above it is requesting.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW  = arb_idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   prio_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Two passes: upper window [prio, N) first, then the wrapped window [0, prio).
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!valid_o && req_i[i] && (IdxW'(i) >= prio_i)) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of one UART TX byte port. The owner
// keeps the port until its last byte is accepted or it stalls past the timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                        clk_sys_i,
  input  logic                        rst_sys_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*UartByteW-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_last_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        tx_valid_o,
  output logic [UartByteW-1:0]        tx_data_o,
  input  logic                        tx_ready_i,
  output logic [NumReq-1:0]           grant_o,
  output logic                        timeout_o
);

  localparam int unsigned IdxW    = arb_idx_w(NumReq);
  localparam int unsigned CntW    = arb_cnt_w(TimeoutCycles);
  localparam int unsigned CntLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntW-1:0] CntMax = CntLast[CntW-1:0];
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [NumReq-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]       prio_q, prio_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  txv_q, txv_d;
  logic [UartByteW-1:0]  txd_q, txd_d;

  logic [NumReq-1:0]     pick_gnt;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;

  logic                  own_valid, own_last;
  logic [UartByteW-1:0]  own_data;
  logic                  locked, tx_space, accept, cnt_hit;
  logic [IdxW-1:0]       prio_next;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req_i   (req_valid_i),
    .prio_i  (prio_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Route the current owner's valid/last/data through a one-hot mux.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_q[i]) begin
        own_valid = req_valid_i[i];
        own_last  = req_last_i[i];
        own_data  = req_data_i[i*UartByteW +: UartByteW];
      end
    end
  end

  assign locked    = (state_q == ArbLocked);
  // Output slot is free when empty or draining this cycle.
  assign tx_space  = !txv_q || tx_ready_i;
  assign accept    = locked && own_valid && tx_space;
  // Only cycles with the owner's valid low advance the stall counter, so
  // tx backpressure alone never revokes a grant.
  assign cnt_hit   = TimeoutEn && locked && !own_valid && (cnt_q == CntMax);
  assign prio_next = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);

  assign req_ready_o = grant_q & {NumReq{locked && tx_space}};
  assign tx_valid_o  = txv_q;
  assign tx_data_o   = txd_q;
  assign grant_o     = grant_q;
  assign timeout_o   = cnt_hit;

  // Arbitration FSM: pick in IDLE, hold through the message in LOCKED.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (pick_valid) begin
          state_d = ArbLocked;
          owner_d = pick_idx;
          grant_d = pick_gnt;
          cnt_d   = '0;
        end
      end
      ArbLocked: begin
        if (accept) begin
          // An accepted last byte wins over a timeout in the same cycle.
          cnt_d = '0;
          if (own_last) begin
            state_d = ArbIdle;
            grant_d = '0;
            prio_d  = prio_next;
          end
        end else if (TimeoutEn && !own_valid) begin
          if (cnt_hit) begin
            state_d = ArbIdle;
            grant_d = '0;
            prio_d  = prio_next;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = ArbIdle;
        grant_d = '0;
      end
    endcase
  end

  // Output byte register: load on accept, otherwise clear valid on drain.
  always_comb begin
    txv_d = txv_q;
    txd_d = txd_q;
    if (accept) begin
      txv_d = 1'b1;
      txd_d = own_data;
    end else if (tx_ready_i) begin
      txv_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any in-flight byte and lock.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= ArbIdle;
      owner_q <= '0;
      grant_q <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the demo system's single UART transmitter between several byte-stream requesters (e.g. the core's UART peripheral and a hardware status reporter). Message-granular round-robin arbiter: a requester holds the transmitter from its first byte until the byte flagged `last`, or until it stalls past a timeout. Sits between the requesters and the UART TX byte input inside `ibex_demo_system`, clocked by `clk_sys`.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters, ≥2.
- `TimeoutCycles`, default 1024: idle cycles a locked requester may stall mid-message before losing the grant. 0 disables the timeout.

Ports:
- `clk_sys_i` in 1: system clock.
- `rst_sys_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid_i` in NumReq: per-requester byte valid.
- `req_data_i` in NumReq*8: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last_i` in NumReq: the byte is the final byte of its message.
- `req_ready_o` out NumReq: byte accepted when valid & ready.
- `tx_valid_o` out 1: output byte valid.
- `tx_data_o` out 8: output byte.
- `tx_ready_i` in 1: UART TX accepts the byte.
- `grant_o` out NumReq: one-hot current owner, all-zero when idle.
- `timeout_o` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE, LOCKED.
- IDLE: if any `req_valid_i` is high, pick the first valid index at or above `prio_q`, wrapping modulo NumReq. Register it as the owner and enter LOCKED next cycle. No byte is accepted in IDLE.
- LOCKED: `req_ready_o[owner] = !tx_valid_o | tx_ready_i`. All other readies are 0.
- Accepted byte loads the output register: `tx_data_o` ← data, `tx_valid_o` ← 1. The register clears on `tx_valid_o & tx_ready_i` with no new load. Simultaneous drain and load keeps valid high with the new data.
- Accepting a byte with `req_last_i` = 1 causes: IDLE next cycle; `prio_q` ← owner+1 mod NumReq; `grant_o` ← 0.
- Timeout counter:
  - Cleared on entry to LOCKED and on every accepted byte.
  - Increments each LOCKED cycle in which `req_valid_i[owner]` = 0.
  - Cycles stalled by `tx_ready_i` = 0 with valid high do not count.
  - When the counter reaches TimeoutCycles−1 in a counting cycle: `timeout_o` pulses that cycle, IDLE next cycle, `prio_q` ← owner+1.
  - Counter width is $clog2(TimeoutCycles+1).
- The output register keeps draining regardless of FSM state. A byte already accepted is never dropped, except on reset.
- Reset values:
  - `tx_valid_o` = 0, `tx_data_o` = 0.
  - `grant_o` = 0, `req_ready_o` = 0, `timeout_o` = 0.
  - State IDLE, `prio_q` = 0, counter = 0.
- Reset mid-message discards the in-flight byte and the lock immediately (asynchronous).

## Timing
- Request at cycle 0 while IDLE → `grant_o` set at cycle 1 → first byte accepted at cycle 1 at the earliest → `tx_valid_o` at cycle 2.
- Sustained throughput is 1 byte/cycle while `tx_ready_i` = 1.
- `req_ready_o` depends combinationally on `tx_ready_i`. All other outputs are registered, except `timeout_o`, which is decoded from registers.
- Message turnaround: last byte accepted at cycle N → IDLE at N+1 → next owner granted at N+2. This gives one bubble cycle per message.
- A byte with `last` accepted in the same cycle the timeout would fire counts as acceptance, so no timeout fires.
- A single requester that is continuously valid regains the grant after each message. Round-robin only moves `prio_q`; it does not block a lone requester.

## Structure
- Package `uart_arb_pkg`: state enum `arb_state_e` {ArbIdle, ArbLocked} and the byte width constant `UartByteW = 8`.
- Sub-module `rr_arbiter`: combinational rotating-priority pick.
  - Inputs: request vector, `prio_q`.
  - Outputs: one-hot grant and its index.
  - Instantiated once.
- FSM, timeout counter and output register live in `uart_tx_arbiter`.

## Test plan
- **Single message:** req0 sends 0x48, 0x69, 0x0A (last on 0x0A) with `tx_ready_i` = 1. → `tx_data_o` shows 48, 69, 0A on cycles 2–4; `grant_o` = 01 on cycles 1–3; `grant_o` = 00 on cycle 4.
- **Contention:** req0 and req1 are both valid from reset, each with 2-byte messages.
  - → req0 is served first, then req1, then req0.
  - → Bytes are never interleaved within a message.
  - → There is exactly one bubble cycle between messages.
- **Backpressure:** `tx_ready_i` = 0 for 50 cycles mid-message with TimeoutCycles = 16. → No timeout; no byte is lost or duplicated; the output holds stable data.
- **Timeout:** req1 locked, sends 1 byte, then drops valid, with TimeoutCycles = 16.
  - → `timeout_o` pulses on the 16th idle cycle.
  - → req0, which has been waiting, is granted 2 cycles later.
- **Reset mid-message:** assert `rst_sys_ni` low while `tx_valid_o` = 1. → All outputs read 0 immediately; after release, req1 alone is granted with `prio_q` = 0 behaviour.
- **TimeoutCycles = 0:** requester idles for 5000 cycles mid-message. → Grant is retained and `timeout_o` never pulses.
